sound_request_arbiter: RTL

//  Parametrised successor of the game's sound request mux. Captures sound events from NUM_CH sources.

---
 rtl/sound_request_arbiter_pkg.sv | 17 +
 rtl/sound_request_arbiter_if.sv | 21 ++
 rtl/sound_request_arbiter_prio_enc.sv | 21 ++
 rtl/sound_request_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sound_request_arbiter_pkg.sv
// Shared types and sizing helpers for the sound request arbiter.
// Optional preemption is enabled by defining SOUND_ARB_PREEMPT_EN.
package sound_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OFFER,
    S_PLAY,
    S_GAP
  } snd_arb_state_t;

  // Channel index width; a single bit is kept even for the smallest arbiter.
  function automatic int chWidth(input int numCh);
    return (numCh > 2) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/sound_request_arbiter_if.sv
// Offer/accept handshake between the arbiter and the audio player.
// play_abort only ever pulses in builds with SOUND_ARB_PREEMPT_EN defined.
interface sound_request_arbiter_if #(
  parameter int CH_W = 2
);
  logic            play_valid;
  logic            play_ready;
  logic            play_done;
  logic            play_abort;
  logic [CH_W-1:0] play_ch;

  modport master (
    output play_valid, play_ch, play_abort,
    input  play_ready, play_done
  );

  modport slave (
    input  play_valid, play_ch, play_abort,
    output play_ready, play_done
  );
endinterface

// File: rtl/sound_request_arbiter_prio_enc.sv
// Fixed-priority finder: lowest set index wins, any flags a non-empty vector.
module sound_prio_enc
  import sound_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]           vec,
  output logic [chWidth(NUM_CH)-1:0]  idx,
  output logic                        any
);
  localparam int CH_W = chWidth(NUM_CH);

  // scan high to low so the last hit, i.e. the lowest index, is kept
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = CH_W'(i);
    end
  end
endmodule

// File: rtl/sound_request_arbiter.sv
// Sound request arbiter: latches rising-edge events per channel, offers the
// highest-priority pending channel to the audio player, waits for play_done
// and then enforces a silent gap of GAP_CYCLES before the next offer.
// Define SOUND_ARB_PREEMPT_EN to let a strictly higher-priority event abort
// the sound that is currently playing.
module sound_request_arbiter
  import sound_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      req,
  sound_request_arbiter_if.master play,
  output logic [NUM_CH-1:0]      pending,
  output logic                   busy
);
  localparam int CH_W  = chWidth(NUM_CH);
  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  snd_arb_state_t    state, stateNxt;
  logic [NUM_CH-1:0] reqD, ev, clr;
  logic [CH_W-1:0]   chQ, chNxt, selIdx;
  logic              validQ, validNxt, selAny, handshake;
  logic [CNT_W-1:0]  gapCnt, gapNxt;

  assign ev        = req & ~reqD;
  assign handshake = (state == S_OFFER) && validQ && play.play_ready;

  // one clear strobe per channel, raised only on that channel's handshake
  for (genvar i = 0; i < NUM_CH; i++) begin : g_clr
    assign clr[i] = handshake && (chQ == CH_W'(i));
  end

  sound_prio_enc #(.NUM_CH(NUM_CH)) u_prio (
    .vec (pending),
    .idx (selIdx),
    .any (selAny)
  );

`ifdef SOUND_ARB_PREEMPT_EN
  logic abortQ, abortNxt;
  assign play.play_abort = abortQ;
`else
  assign play.play_abort = 1'b0;
`endif

  // edge history and event latch; a new event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      reqD    <= '0;
      pending <= '0;
    end else begin
      reqD    <= req;
      pending <= (pending & ~clr) | ev;
    end
  end

  // next-state and output decisions for the offer/play/gap sequence
  always_comb begin
    stateNxt = state;
    chNxt    = chQ;
    validNxt = validQ;
    gapNxt   = gapCnt;
`ifdef SOUND_ARB_PREEMPT_EN
    abortNxt = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (selAny) begin
          stateNxt = S_OFFER;
          chNxt    = selIdx;
          validNxt = 1'b1;
        end
      end
      S_OFFER: begin
        // offer is never retracted, even if a better channel shows up
        if (handshake) begin
          stateNxt = S_PLAY;
          validNxt = 1'b0;
        end
      end
      S_PLAY: begin
`ifdef SOUND_ARB_PREEMPT_EN
        // abort pulse is out: re-offer straight away, no gap
        if (abortQ) begin
          stateNxt = S_OFFER;
          chNxt    = selIdx;
          validNxt = 1'b1;
        end else
`endif
        if (play.play_done) begin
          if (GAP_CYCLES == 0) begin
            stateNxt = S_IDLE;
          end else begin
            stateNxt = S_GAP;
            gapNxt   = CNT_W'(GAP_CYCLES);
          end
        end
`ifdef SOUND_ARB_PREEMPT_EN
        else if (selAny && (selIdx < chQ)) begin
          abortNxt = 1'b1;
        end
`endif
      end
      S_GAP: begin
        gapNxt = (gapCnt != '0) ? gapCnt - CNT_W'(1) : '0;
        if (gapCnt <= CNT_W'(1)) stateNxt = S_IDLE;
      end
      default: stateNxt = S_IDLE;
    endcase
  end

  // state, offer and gap counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      chQ    <= '0;
      validQ <= 1'b0;
      gapCnt <= '0;
`ifdef SOUND_ARB_PREEMPT_EN
      abortQ <= 1'b0;
`endif
    end else begin
      state  <= stateNxt;
      chQ    <= chNxt;
      validQ <= validNxt;
      gapCnt <= gapNxt;
`ifdef SOUND_ARB_PREEMPT_EN
      abortQ <= abortNxt;
`endif
    end
  end

  assign play.play_valid = validQ;
  assign play.play_ch    = chQ;
  assign busy            = (state != S_IDLE);

endmodule
